// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: single-master to N-slave address-decoded bus bridge with wait-state timeout
// and error reporting.
module soc_bus_fabric #(
  parameter int                      N_SLAVES   = 4,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {32'h0000_8000, 32'h0000_5000, 32'h0004_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_F800, 32'hFFFF_F800},
  parameter int                      TIMEOUT    = 255,
  parameter logic [31:0]             ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [N_SLAVES-1:0]      s_valid,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [N_SLAVES-1:0]      s_ready,
  input  logic [N_SLAVES*32-1:0]   s_rdata,
  output logic                     err_irq,
  output logic [31:0]              err_addr,
  output logic [15:0]              err_count
);
  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t        r_state, w_next;
  logic [SW-1:0] r_sel, w_idx;
  logic          w_hit, w_rdy, w_tmo, r_err;
  logic [31:0]   r_addr, r_wdata, r_rdata, r_err_addr;
  logic [3:0]    r_wstrb;
  logic [15:0]   r_cnt, r_err_count;
  // Scan high to low so the lowest matching index is the one left standing
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--)
      if ((mem_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        w_hit = 1'b1;
        w_idx = SW'(i);
      end
  end
  assign w_rdy = s_ready[r_sel];
  assign w_tmo = r_cnt == 16'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE)   ? (mem_valid ? (w_hit ? ACCESS : RESP) : IDLE) :
             (r_state == ACCESS) ? ((w_rdy || w_tmo) ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sel       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rdata     <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_err_addr  <= '0;
      r_err_count <= '0;
    end else if (r_state == IDLE && mem_valid) begin
      r_sel   <= w_idx;
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      r_wstrb <= mem_wstrb;
      r_cnt   <= '0;
      r_err   <= !w_hit;
      if (!w_hit) begin
        r_rdata     <= ERR_RDATA;
        r_err_addr  <= mem_addr;
        r_err_count <= (&r_err_count) ? r_err_count : r_err_count + 16'd1;
      end
    end else if (r_state == ACCESS) begin
      if (w_rdy) r_rdata <= s_rdata[int'(r_sel)*32 +: 32];
      else if (w_tmo) begin
        r_err       <= 1'b1;
        r_rdata     <= ERR_RDATA;
        r_err_addr  <= r_addr;
        r_err_count <= (&r_err_count) ? r_err_count : r_err_count + 16'd1;
      end else r_cnt <= r_cnt + 16'd1;
    end
  end
  // Handshake outputs decode straight from flops, so mem_valid never reaches them combinationally
  always_comb begin
    s_valid   = (r_state == ACCESS) ? N_SLAVES'(1) << r_sel : '0;
    mem_ready = r_state == RESP;
    err_irq   = (r_state == RESP) && r_err;
  end
  assign s_addr    = r_addr & ~SLAVE_MASK[int'(r_sel)*32 +: 32];
  assign s_wdata   = r_wdata;
  assign s_wstrb   = r_wstrb;
  assign mem_rdata = r_rdata;
  assign err_addr  = r_err_addr;
  assign err_count = r_err_count;
endmodule

// File: tb/tb_soc_bus_fabric.sv
// tb_soc_bus_fabric: directed checks of decode, latency, timeout, reset abort and error counter
// saturation.
module tb_soc_bus_fabric;
  logic         clk = 1'b0, resetn = 1'b0;
  logic         mem_valid = 1'b0;
  logic [31:0]  mem_addr = '0, mem_wdata = '0;
  logic [3:0]   mem_wstrb = '0;
  logic         mem_ready, err_irq;
  logic [31:0]  mem_rdata, s_addr, s_wdata, err_addr;
  logic [3:0]   s_valid, s_wstrb;
  logic [3:0]   s_ready = '0;
  logic [127:0] s_rdata = '0;
  logic [15:0]  err_count;
  int           n_tests = 0, n_fail = 0, n_cyc;

  soc_bus_fabric dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .err_irq(err_irq),
    .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h1111_1111};
    #2;
    chk("rst_ready", 32'(mem_ready), 0);
    chk("rst_svalid", 32'(s_valid), 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_saddr", s_addr, 0);
    chk("rst_irq", 32'(err_irq), 0);
    chk("rst_eaddr", err_addr, 0);
    chk("rst_ecnt", 32'(err_count), 0);
    step();
    resetn = 1'b1;
    // Mapped read to slave 1, zero wait
    mem_valid = 1'b1; mem_addr = 32'h0004_0010; mem_wstrb = 4'b0000; s_ready = 4'b0010;
    step();
    mem_valid = 1'b0; mem_addr = 32'hFFFF_FFFF;
    chk("rd_svalid", 32'(s_valid), 32'b0010);
    chk("rd_saddr", s_addr, 32'h10);
    chk("rd_ready0", 32'(mem_ready), 0);
    step();
    chk("rd_ready", 32'(mem_ready), 1);
    chk("rd_rdata", mem_rdata, 32'h1234_5678);
    chk("rd_irq", 32'(err_irq), 0);
    step();
    chk("rd_done", 32'(mem_ready), 0);
    // Write to slave 2 with one wait cycle; other slaves' ready is ignored
    mem_valid = 1'b1; mem_addr = 32'h0000_5004; mem_wstrb = 4'b0001; mem_wdata = 32'hA5; s_ready = 4'b0000;
    step();
    mem_valid = 1'b0; mem_wdata = 32'h0; mem_wstrb = 4'b1111; s_ready = 4'b1011;
    chk("wr_svalid", 32'(s_valid), 32'b0100);
    chk("wr_saddr", s_addr, 32'h4);
    chk("wr_wstrb", 32'(s_wstrb), 32'b0001);
    chk("wr_wdata", s_wdata, 32'hA5);
    step();
    chk("wr_ignore_ready", 32'(mem_ready), 0);
    chk("wr_hold_svalid", 32'(s_valid), 32'b0100);
    s_ready = 4'b0100;
    step();
    chk("wr_ready", 32'(mem_ready), 1);
    chk("wr_ecnt", 32'(err_count), 0);
    chk("wr_irq", 32'(err_irq), 0);
    step();
    s_ready = 4'b0000;
    // Unmapped read
    mem_valid = 1'b1; mem_addr = 32'h0010_0000; mem_wstrb = 4'b0000;
    step();
    mem_valid = 1'b0;
    chk("um_ready", 32'(mem_ready), 1);
    chk("um_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("um_irq", 32'(err_irq), 1);
    chk("um_eaddr", err_addr, 32'h0010_0000);
    chk("um_ecnt", 32'(err_count), 1);
    chk("um_svalid", 32'(s_valid), 0);
    step();
    chk("um_irq_off", 32'(err_irq), 0);
    chk("um_ready_off", 32'(mem_ready), 0);
    // Timeout on slave 3
    mem_valid = 1'b1; mem_addr = 32'h0000_8000;
    step();
    mem_valid = 1'b0;
    n_cyc = 0;
    while (s_valid === 4'b1000 && mem_ready !== 1'b1 && n_cyc < 400) begin
      n_cyc++;
      step();
    end
    chk("to_cycles", 32'(n_cyc), 255);
    chk("to_svalid", 32'(s_valid), 0);
    chk("to_ready", 32'(mem_ready), 1);
    chk("to_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("to_irq", 32'(err_irq), 1);
    chk("to_ecnt", 32'(err_count), 2);
    chk("to_eaddr", err_addr, 32'h0000_8000);
    step();
    // Reset during the third ACCESS cycle
    mem_valid = 1'b1; mem_addr = 32'h0004_0020; s_ready = 4'b0000;
    step();
    mem_valid = 1'b0;
    step();
    step();
    chk("ra_svalid", 32'(s_valid), 32'b0010);
    #1 resetn = 1'b0;
    #1;
    chk("ra_svalid0", 32'(s_valid), 0);
    chk("ra_ready", 32'(mem_ready), 0);
    chk("ra_rdata", mem_rdata, 0);
    chk("ra_saddr", s_addr, 0);
    chk("ra_ecnt", 32'(err_count), 0);
    chk("ra_eaddr", err_addr, 0);
    s_ready = 4'b0010;
    step();
    chk("ra_hold_ready", 32'(mem_ready), 0);
    step();
    chk("ra_hold_ready2", 32'(mem_ready), 0);
    s_rdata[63:32] = 32'hCAFE_F00D;
    mem_valid = 1'b1; mem_addr = 32'h0004_0008;
    resetn = 1'b1;
    step();
    mem_valid = 1'b0;
    chk("pr_svalid", 32'(s_valid), 32'b0010);
    chk("pr_saddr", s_addr, 32'h8);
    step();
    chk("pr_ready", 32'(mem_ready), 1);
    chk("pr_rdata", mem_rdata, 32'hCAFE_F00D);
    step();
    s_ready = 4'b0000;
    // Error counter saturation, counter preloaded near the top
    force dut.r_err_count = 16'hFFFE;
    #1 release dut.r_err_count;
    mem_valid = 1'b1; mem_addr = 32'h0010_0004;
    step();
    mem_valid = 1'b0;
    chk("sat_ecnt1", 32'(err_count), 32'hFFFF);
    chk("sat_irq1", 32'(err_irq), 1);
    step();
    mem_valid = 1'b1; mem_addr = 32'h0010_0008;
    step();
    mem_valid = 1'b0;
    chk("sat_ecnt2", 32'(err_count), 32'hFFFF);
    chk("sat_irq2", 32'(err_irq), 1);
    chk("sat_ready", 32'(mem_ready), 1);
    chk("sat_eaddr", err_addr, 32'h0010_0008);
    step();
    chk("sat_irq_off", 32'(err_irq), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/soc_bus_fabric.md
SOC_BUS_FABRIC -- requirements
Module: soc_bus_fabric

Interface
REQ-001 Parameter N_SLAVES, default 4: number of slave ports (1..8).
REQ-002 Parameter SLAVE_BASE, default {32'h0000_8000, 32'h0000_5000, 32'h0004_0000, 32'h0000_0000}: packed N_SLAVES*32 region base addresses, slave 0 in bits [31:0].
REQ-003 Parameter SLAVE_MASK, default {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_F800, 32'hFFFF_F800}: packed per-slave address compare masks.
REQ-004 Parameter TIMEOUT, default 255: maximum slave wait cycles (1..65535).
REQ-005 Parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on an error response.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 mem_valid, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]  input: CPU request; wstrb==0 means read.
REQ-009 mem_ready  output  1  single-cycle completion strobe; mem_rdata  output  32  response data.
REQ-010 s_valid  output  N_SLAVES  one-hot slave request; s_addr, s_wdata  output  32; s_wstrb  output  4.
REQ-011 s_ready  input  N_SLAVES; s_rdata  input  N_SLAVES*32, slave 0 in bits [31:0].
REQ-012 err_irq  output  1  one-cycle error pulse; err_addr  output  32  last faulting address; err_count  output  16  error total.

Function
REQ-013 Decode: slave i matches when (mem_addr & MASK[i]) == BASE[i]; on multiple matches, the lowest index wins.
REQ-014 FSM states: IDLE, ACCESS, RESP.
REQ-015 IDLE, mem_valid=1, match found: latch index, addr, wdata, wstrb; go to ACCESS; clear the wait counter.
REQ-016 IDLE, mem_valid=1, no match: go to RESP with error flag set; no s_valid is asserted.
REQ-017 ACCESS: drive s_valid[sel]=1 with the latched request; s_addr = latched addr & ~MASK[sel] (region offset).
REQ-018 ACCESS with s_ready[sel]=1: register s_rdata[sel] into mem_rdata; go to RESP.
REQ-019 ACCESS without s_ready[sel]: increment the counter; when the counter reaches TIMEOUT, drop s_valid, set the error flag, and go to RESP.
REQ-020 s_ready bits of unselected slaves are ignored.
REQ-021 RESP: mem_ready=1 for exactly one cycle, then return to IDLE; mem_rdata is ERR_RDATA on error, otherwise the captured data.
REQ-022 Latency: a mapped access with a zero-wait slave raises mem_ready 2 cycles after mem_valid is sampled; an unmapped access raises it after 1 cycle; a timeout raises it after TIMEOUT+1 cycles.
REQ-023 Changes to mem_* while in ACCESS or RESP are ignored; the latched request completes.
REQ-024 A new request is accepted only in IDLE; back-to-back requests have a minimum gap of 1 IDLE cycle.
REQ-025 On error entry to RESP: err_irq=1 for one cycle, err_addr is loaded with the faulting address, and err_count increments, saturating at 16'hFFFF.
REQ-026 Write errors behave the same as read errors; for any write, mem_rdata is don't-care.
REQ-027 mem_ready, s_valid, and err_irq are registered outputs with no combinational path from mem_valid.

Reset
REQ-028 resetn=0 asynchronously forces IDLE and sets mem_ready=0, s_valid=0, mem_rdata=0, s_addr=0, s_wdata=0, s_wstrb=0, err_irq=0, err_addr=0, err_count=0, and counter=0.
REQ-029 Reset in ACCESS drops s_valid immediately, and the aborted transaction never produces mem_ready.
REQ-030 After resetn rises, the first request may be accepted on the first rising edge.

Verification
REQ-031 Read 0x0004_0010, slave1 s_ready=1 in the first ACCESS cycle with s_rdata=0x1234_5678 -> s_valid=4'b0010, s_addr=0x10; mem_ready 2 cycles later with rdata 0x1234_5678.
REQ-032 Write 0x0000_5004, wstrb=4'b0001, wdata=0xA5 -> s_valid=4'b0100, s_addr=0x4, s_wstrb=4'b0001; mem_ready when slave2 acks; err_count stays 0.
REQ-033 Read 0x0010_0000 (unmapped) -> mem_ready after 1 cycle, rdata 0xDEAD_BEEF, err_irq pulse, err_addr=0x0010_0000, err_count=1.
REQ-034 Read 0x0000_8000 with slave3 never ready, TIMEOUT=255 -> s_valid held 255 cycles then dropped; mem_ready with 0xDEAD_BEEF; err_count increments.
REQ-035 Assert resetn=0 in the 3rd ACCESS cycle -> s_valid=0 at once, no mem_ready, all outputs 0; the next request completes normally.
REQ-036 With err_count preset to 0xFFFF via repeated errors, one more unmapped access -> err_count stays 0xFFFF and err_irq still pulses.
